// File: rtl/pacman_pkg.sv
// Shared types, maze geometry and orientation helper for the Pac-Man motion controller.
package pacman_pkg;

  localparam int TILE = 8;
  localparam int COLS = 28;
  localparam int ROWS = 36;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    IDLE,
    Q_REQ,
    Q_CUR,
    STEP,
    STOP
  } state_t;

  // Returns {h_flip, v_flip} for the sprite renderer.
  function automatic logic [1:0] dir_to_flip(input dir_t d);
    case (d)
      RIGHT:   return 2'b11;
      LEFT:    return 2'b01;
      UP:      return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/pacman_neighbour_tile.sv
// Combinational neighbour-tile calculator: tile coordinates one step away in a direction.
// Columns wrap around the tunnel; rows outside the maze are flagged instead of wrapped.
module pacman_neighbour_tile
  import pacman_pkg::*;
(
  input  logic [5:0] x_tile,
  input  logic [5:0] y_tile,
  input  dir_t       dir,
  output logic [4:0] tx,
  output logic [5:0] ty,
  output logic       out_of_range
);

  logic [4:0] col;
  logic [6:0] row;

  always_comb begin
    col = 5'(x_tile);
    row = {1'b0, y_tile};
    case (dir)
      RIGHT:   col = (x_tile >= 6'(COLS - 1)) ? 5'd0 : 5'(x_tile + 6'd1);
      LEFT:    col = (x_tile == 6'd0) ? 5'(COLS - 1) : 5'(x_tile - 6'd1);
      UP:      row = {1'b0, y_tile} - 7'd1;
      default: row = {1'b0, y_tile} + 7'd1;
    endcase
  end

  // Row -1 underflows to 127, so a single upper-bound test covers both edges.
  assign out_of_range = (row > 7'(ROWS - 1));
  assign tx           = col;
  assign ty           = row[5:0];

endmodule

// File: rtl/pacman_motion_ctrl.sv
// Per-frame Pac-Man motion sequencer: direction latch, wall lookup handshake, position step.
// Optional mouth animation divider is enabled with `define PACMAN_ANIM_EN.
module pacman_motion_ctrl
  import pacman_pkg::*;
#(
  parameter int START_X = 104,
  parameter int START_Y = 208,
  parameter int SPEED   = 1,
  parameter int X_MAX   = 224
`ifdef PACMAN_ANIM_EN
  , parameter int ANIM_DIV = 4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       dir_valid,
  input  logic [1:0] dir_in,
  output logic       wall_req,
  output logic [4:0] wall_tx,
  output logic [5:0] wall_ty,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [8:0] x_pac,
  output logic [8:0] y_pac,
  output logic       h_flip,
  output logic       v_flip,
  output logic       moving,
  output logic       busy,
  output logic       anim_frame,
  output state_t     state_dbg
);

  // Lookup handshake: wall_req rises with wall_tx/wall_ty and all three hold until the
  // cycle wall_ack is seen high; wall_hit is sampled only in that cycle, and an ack
  // arriving while wall_req is low is ignored.

  state_t     state;
  dir_t       cur_dir, req_dir, q_dir, nb_dir;
  logic [4:0] nb_tx;
  logic [5:0] nb_ty;
  logic       nb_oor, aligned, resolved, free;
  logic [9:0] x_wide;
  logic [8:0] next_x, next_y;

  // In IDLE the pending request is probed; afterwards only the current heading is.
  assign nb_dir = (state == IDLE) ? req_dir : cur_dir;

  pacman_neighbour_tile u_neighbour (
    .x_tile       (x_pac[8:3]),
    .y_tile       (y_pac[8:3]),
    .dir          (nb_dir),
    .tx           (nb_tx),
    .ty           (nb_ty),
    .out_of_range (nb_oor)
  );

  assign aligned  = ((x_pac & 9'(TILE - 1)) == 9'd0) && ((y_pac & 9'(TILE - 1)) == 9'd0);
  // A lookup skipped for an out-of-range row resolves at once as a wall.
  assign resolved = !wall_req || wall_ack;
  assign free     = wall_req && !wall_hit;

  always_comb begin
    x_wide = {1'b0, x_pac};
    next_x = x_pac;
    next_y = y_pac;
    case (cur_dir)
      RIGHT: begin
        x_wide = {1'b0, x_pac} + 10'(SPEED);
        next_x = (x_wide >= 10'(X_MAX)) ? 9'd0 : x_wide[8:0];
      end
      LEFT: begin
        x_wide = {1'b0, x_pac} - 10'(SPEED);
        next_x = x_wide[9] ? 9'(X_MAX - SPEED) : x_wide[8:0];
      end
      UP:      next_y = y_pac - 9'(SPEED);
      default: next_y = y_pac + 9'(SPEED);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_pac    <= 9'(START_X);
      y_pac    <= 9'(START_Y);
      cur_dir  <= LEFT;
      req_dir  <= LEFT;
      q_dir    <= LEFT;
      wall_req <= 1'b0;
      wall_tx  <= 5'd0;
      wall_ty  <= 6'd0;
      moving   <= 1'b0;
    end else begin
      if (dir_valid) req_dir <= dir_t'(dir_in);
      case (state)
        IDLE: begin
          if (frame_tick) begin
            if (aligned) begin
              state    <= Q_REQ;
              q_dir    <= req_dir;
              wall_req <= !nb_oor;
              wall_tx  <= nb_tx;
              wall_ty  <= nb_ty;
            end else begin
              state <= STEP;
            end
          end
        end
        Q_REQ: begin
          if (resolved) begin
            wall_req <= 1'b0;
            if (free) begin
              cur_dir <= q_dir;
              state   <= STEP;
            end else if (q_dir == cur_dir) begin
              state <= STOP;
            end else begin
              state    <= Q_CUR;
              wall_req <= !nb_oor;
              wall_tx  <= nb_tx;
              wall_ty  <= nb_ty;
            end
          end
        end
        Q_CUR: begin
          if (resolved) begin
            wall_req <= 1'b0;
            state    <= free ? STEP : STOP;
          end
        end
        STEP: begin
          x_pac  <= next_x;
          y_pac  <= next_y;
          moving <= 1'b1;
          state  <= IDLE;
        end
        STOP: begin
          moving <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign {h_flip, v_flip} = dir_to_flip(cur_dir);
  assign busy             = (state != IDLE);
  assign state_dbg        = state;

`ifdef PACMAN_ANIM_EN
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  logic [AW-1:0] anim_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      anim_cnt   <= '0;
      anim_frame <= 1'b0;
    end else if (state == STEP) begin
      if (anim_cnt == AW'(ANIM_DIV - 1)) begin
        anim_cnt   <= '0;
        anim_frame <= !anim_frame;
      end else begin
        anim_cnt <= anim_cnt + 1'b1;
      end
    end
  end
`else
  assign anim_frame = 1'b0;
`endif

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
// Self-checking bench for pacman_motion_ctrl: directed scenarios plus a random maze walk,
// each frame compared against a tile/pixel-level reference model.
module tb_pacman_motion_ctrl;
  import pacman_pkg::*;

  logic       clk = 1'b0, rst = 1'b1, frame_tick = 1'b0, dir_valid = 1'b0;
  logic [1:0] dir_in = 2'd0;
  logic       wall_req, wall_ack = 1'b0, wall_hit = 1'b0;
  logic [4:0] wall_tx;
  logic [5:0] wall_ty;
  logic [8:0] x_pac, y_pac;
  logic       h_flip, v_flip, moving, busy, anim_frame;
  state_t     state_dbg;

  always #5 clk = ~clk;

  pacman_motion_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .dir_valid(dir_valid), .dir_in(dir_in),
    .wall_req(wall_req), .wall_tx(wall_tx), .wall_ty(wall_ty), .wall_ack(wall_ack),
    .wall_hit(wall_hit), .x_pac(x_pac), .y_pac(y_pac), .h_flip(h_flip), .v_flip(v_flip),
    .moving(moving), .busy(busy), .anim_frame(anim_frame), .state_dbg(state_dbg)
  );

  int n_vec = 0, n_err = 0;
  bit maze [0:35][0:27];
  int m_x, m_y, m_cur, m_req, m_steps;
  bit m_moving;
  logic [10:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (model x=%0d y=%0d)", tag, obs, exp, m_x, m_y);
    end
  endtask

  // Direction codes 0..3 = RIGHT, LEFT, UP, DOWN; orientation {h,v} as a 2-bit number.
  function automatic int exp_flip(input int d);
    case (d)
      0: return 3;
      1: return 1;
      2: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_anim();
`ifdef PACMAN_ANIM_EN
    return (m_steps / 4) % 2;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_x = 104; m_y = 208; m_cur = 1; m_req = 1; m_steps = 0; m_moving = 0;
    exp_q.delete();
  endtask

  // Returns whether the neighbour of the model position in direction d blocks movement,
  // queueing the tile the DUT is expected to query when it lies inside the maze.
  function automatic bit model_probe(input int d);
    int c, r;
    c = m_x / 8 + ((d == 0) ? 1 : (d == 1) ? -1 : 0);
    r = m_y / 8 + ((d == 3) ? 1 : (d == 2) ? -1 : 0);
    c = (c + 28) % 28;
    if (r < 0 || r > 35) return 1'b1;
    exp_q.push_back({5'(c), 6'(r)});
    return maze[r][c];
  endfunction

  task automatic model_frame();
    bit go;
    go = 1'b1;
    if (m_x % 8 == 0 && m_y % 8 == 0) begin
      if (!model_probe(m_req)) m_cur = m_req;
      else if (m_req == m_cur) go = 1'b0;
      else go = !model_probe(m_cur);
    end
    m_moving = go;
    if (go) begin
      m_steps++;
      case (m_cur)
        0: begin m_x = m_x + 1; if (m_x >= 224) m_x = 0; end
        1: begin m_x = m_x - 1; if (m_x < 0) m_x = 223; end
        2: m_y = m_y - 1;
        default: m_y = m_y + 1;
      endcase
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic set_dir(input int d);
    @(negedge clk); dir_valid = 1'b1; dir_in = 2'(d); m_req = d;
    @(negedge clk); dir_valid = 1'b0;
  endtask

  task automatic do_frame(input int ack_dly, input bit extra_tick, input bit rand_dir);
    int guard;
    logic [10:0] obs;
    model_frame();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    guard = 0;
    while (busy && guard < 200) begin
      if (wall_req) begin
        obs = {wall_tx, wall_ty};
        if (exp_q.size() == 0) check("unexpected_query", obs, 11'h7ff);
        else check("query_tile", obs, exp_q.pop_front());
        for (int i = 0; i < ack_dly; i++) begin
          @(negedge clk);
          frame_tick = extra_tick && (i == 2);
          dir_valid  = 1'b0;
          if (rand_dir && $urandom_range(0, 7) == 0) begin
            dir_valid = 1'b1; dir_in = 2'($urandom_range(0, 3)); m_req = int'(dir_in);
          end
          check("tile_stable", {wall_req, wall_tx, wall_ty}, {1'b1, obs});
        end
        frame_tick = 1'b0;
        wall_ack = 1'b1;
        wall_hit = (wall_ty < 6'd36 && wall_tx < 5'd28) ? maze[wall_ty][wall_tx] : 1'b1;
        @(negedge clk);
        wall_ack = 1'b0; wall_hit = 1'b0; dir_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      guard++;
    end
    check("frame_done", busy, 1'b0);
    check("x_pac", x_pac, m_x);
    check("y_pac", y_pac, m_y);
    check("flip", {h_flip, v_flip}, exp_flip(m_cur));
    check("moving", moving, m_moving);
    check("anim_frame", anim_frame, exp_anim());
    check("missing_query", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int g;
    foreach (maze[r, c]) maze[r][c] = 1'b0;

    // Reset state, then one free-path frame from the start position.
    do_reset();
    check("rst_x", x_pac, 104);
    check("rst_y", y_pac, 208);
    check("rst_flip", {h_flip, v_flip}, 2'b01);
    check("rst_moving", moving, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_wall_req", wall_req, 1'b0);
    check("rst_anim", anim_frame, 1'b0);
    check("rst_state", state_dbg, IDLE);
    do_frame(0, 0, 0);
    check("t1_x", x_pac, 103);

    // Turn right at the start tile.
    do_reset();
    set_dir(0);
    do_frame(1, 0, 0);
    check("t2_x", x_pac, 105);
    check("t2_flip", {h_flip, v_flip}, 2'b11);

    // Walk to (64,64) heading left, then block both up and left.
    do_reset();
    set_dir(2);
    repeat (144) do_frame(0, 0, 0);
    set_dir(1);
    repeat (40) do_frame(1, 0, 0);
    maze[7][8] = 1'b1;
    maze[8][7] = 1'b1;
    set_dir(2);
    do_frame(2, 0, 0);
    check("t3_x", x_pac, 64);
    check("t3_y", y_pac, 64);
    check("t3_moving", moving, 1'b0);
    maze[7][8] = 1'b0;
    maze[8][7] = 1'b0;

    // Tunnel wrap both ways.
    set_dir(1);
    repeat (64) do_frame(0, 0, 0);
    check("t4_x0", x_pac, 0);
    do_frame(0, 0, 0);
    check("t4_wrap_left", x_pac, 223);
    repeat (7) do_frame(0, 0, 0);
    set_dir(0);
    repeat (7) do_frame(0, 0, 0);
    check("t4_x223", x_pac, 223);
    do_frame(0, 0, 0);
    check("t4_wrap_right", x_pac, 0);

    // Extra tick during a slow lookup is dropped.
    do_frame(10, 1, 0);
    check("t5_x", x_pac, 1);

    // Reset in the middle of a handshake; a late ack must not restart anything.
    do_reset();
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    g = 0;
    while (!wall_req && g < 20) begin @(negedge clk); g++; end
    check("t6_req_seen", wall_req, 1'b1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_req_drop", wall_req, 1'b0);
    check("t6_x", x_pac, 104);
    check("t6_y", y_pac, 208);
    wall_ack = 1'b1;
    @(negedge clk); wall_ack = 1'b0;
    @(negedge clk);
    check("t6_late_busy", busy, 1'b0);
    check("t6_late_x", x_pac, 104);
    model_reset();

    // Eight moving frames for the mouth animation.
    repeat (4) do_frame(0, 0, 0);
`ifdef PACMAN_ANIM_EN
    check("anim_after4", anim_frame, 1'b1);
`endif
    repeat (4) do_frame(0, 0, 0);
`ifdef PACMAN_ANIM_EN
    check("anim_after8", anim_frame, 1'b0);
`endif

    // Random maze walk.
    foreach (maze[r, c]) maze[r][c] = ($urandom_range(0, 3) == 0);
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) set_dir($urandom_range(0, 3));
      do_frame($urandom_range(0, 4), $urandom_range(0, 4) == 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
